dual_issue_scheduler: RTL and testbench

Sequencing controller for the two-slot issue stage. Each cycle it decides which of the two fetched instructions leave IF/ID. It holds the slot-order bit `first` that the hazard detection logic consumes, runs split issue of dependent pairs over two cycles, and holds the pipe on load-use hazards against variable-latency memory. It sits between fetch and the per-slot pipe registers and drives their stall/flush masks.

---
 rtl/dual_issue_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - two-slot issue sequencer: slot order, split issue, load-use stall; counters under SCHED_PERF_CNT_EN
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif
`ifndef REG_RS
`define REG_RS 25:21
`endif
`ifndef REG_RT
`define REG_RT 20:16
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 5'b00100
`endif

module dual_issue_scheduler #(
   parameter int MAX_LOAD_WAIT = 15
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [`INST_WIDTH-1:0]          instruction0,
   input  logic [`INST_WIDTH-1:0]          instruction1,
   input  logic                            pair_valid,
   input  logic                            split_req,
   input  logic                            load_valid,
   input  logic [`NUM_REGISTERS_LOG2-1:0]  load_rt,
   input  logic                            mem_ready,
   output logic                            issue0,
   output logic                            issue1,
   output logic                            first,
   output logic [`NUM_PIPE_MASKS-1:0]      stall_mask,
   output logic [`NUM_PIPE_MASKS-1:0]      flush0,
   output logic [`NUM_PIPE_MASKS-1:0]      flush1,
   output logic                            busy,
   output logic                            load_timeout,
   output logic [15:0]                     split_count,
   output logic [15:0]                     wait_count
);

   typedef enum logic [1:0] {RUN, SPLIT, LOAD_WAIT} state_t;

   state_t     state_q, state_d;
   logic       first_q, first_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       load_timeout_q, load_timeout_d;
   logic       split_enter;
   logic       load_hit;
   logic [`NUM_REGISTERS_LOG2-1:0] rs0, rt0, rs1, rt1;

   // Only the register fields are consumed; the rest of each word is ignored here.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{instruction0, instruction1};

   // Decode source fields and detect a load-use hazard against either slot; r0 never hits.
   always_comb begin
      rs0 = instruction0[`REG_RS];
      rt0 = instruction0[`REG_RT];
      rs1 = instruction1[`REG_RS];
      rt1 = instruction1[`REG_RT];
      load_hit = load_valid && (load_rt != '0) &&
                 ((rs0 == load_rt) || (rt0 == load_rt) || (rs1 == load_rt) || (rt1 == load_rt));
   end

   // Next-state and issue/stall/flush decisions; reset forces every decision output quiet.
   always_comb begin
      state_d        = state_q;
      first_d        = first_q;
      wait_cnt_d     = wait_cnt_q;
      load_timeout_d = load_timeout_q;
      issue0         = 1'b0;
      issue1         = 1'b0;
      stall_mask     = '0;
      flush0         = '0;
      flush1         = '0;
      split_enter    = 1'b0;
      case (state_q)
         RUN: begin
            if (pair_valid) begin
               if (load_hit) begin
                  stall_mask = `PIPE_REG_PC | `PIPE_REG_IF_ID;
                  flush0     = `PIPE_REG_ID_EX;
                  flush1     = `PIPE_REG_ID_EX;
                  if (!mem_ready) begin
                     wait_cnt_d = '0;
                     state_d    = LOAD_WAIT;
                  end
               end else if (split_req) begin
                  stall_mask = `PIPE_REG_PC;
                  if (first_q) begin
                     issue0 = 1'b1;
                     flush1 = `PIPE_REG_ID_EX;
                  end else begin
                     issue1 = 1'b1;
                     flush0 = `PIPE_REG_ID_EX;
                  end
                  split_enter = 1'b1;
                  state_d     = SPLIT;
               end else begin
                  issue0 = 1'b1;
                  issue1 = 1'b1;
               end
            end
         end
         SPLIT: begin
            // Younger slot goes now; the older one already left, so its IF/ID copy is cleared.
            if (first_q) begin
               issue1 = 1'b1;
               flush0 = `PIPE_REG_IF_ID;
            end else begin
               issue0 = 1'b1;
               flush1 = `PIPE_REG_IF_ID;
            end
            first_d = ~first_q;
            state_d = RUN;
         end
         LOAD_WAIT: begin
            stall_mask = `PIPE_REG_PC | `PIPE_REG_IF_ID;
            flush0     = `PIPE_REG_ID_EX;
            flush1     = `PIPE_REG_ID_EX;
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (mem_ready) begin
               state_d = RUN;
            end else if (wait_cnt_d == 8'(MAX_LOAD_WAIT)) begin
               load_timeout_d = 1'b1;
               state_d        = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      busy = (state_q != RUN);
      if (reset) begin
         issue0      = 1'b0;
         issue1      = 1'b0;
         stall_mask  = '0;
         flush0      = '0;
         flush1      = '0;
         busy        = 1'b0;
         split_enter = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         first_q        <= 1'b1;
         wait_cnt_q     <= '0;
         load_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         first_q        <= first_d;
         wait_cnt_q     <= wait_cnt_d;
         load_timeout_q <= load_timeout_d;
      end
   end

   assign first        = first_q;
   assign load_timeout = load_timeout_q;

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] split_count_q, split_count_d;
   logic [15:0] wait_count_q, wait_count_d;

   // Saturating performance counters: split entries and IF/ID-held cycles.
   always_comb begin
      split_count_d = split_count_q;
      wait_count_d  = wait_count_q;
      if (split_enter && (split_count_q != 16'hFFFF))
         split_count_d = split_count_q + 16'd1;
      if (((stall_mask & `PIPE_REG_IF_ID) != '0) && (wait_count_q != 16'hFFFF))
         wait_count_d = wait_count_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         split_count_q <= '0;
         wait_count_q  <= '0;
      end else begin
         split_count_q <= split_count_d;
         wait_count_q  <= wait_count_d;
      end
   end

   assign split_count = split_count_q;
   assign wait_count  = wait_count_q;
`else
   logic unused_split_enter;
   assign unused_split_enter = split_enter;
   assign split_count = 16'd0;
   assign wait_count  = 16'd0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - randomized and directed checks of dual_issue_scheduler against a behavioural model
module tb_dual_issue_scheduler;

   localparam int         MAXW   = 15;
   localparam logic [4:0] M_PC   = 5'b00001;
   localparam logic [4:0] M_IFID = 5'b00010;
   localparam logic [4:0] M_IDEX = 5'b00100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction0, instruction1;
   logic        pair_valid, split_req, load_valid, mem_ready;
   logic [4:0]  load_rt;
   logic        issue0, issue1, first, busy, load_timeout;
   logic [4:0]  stall_mask, flush0, flush1;
   logic [15:0] split_count, wait_count;

   always #5 clk = ~clk;

   dual_issue_scheduler #(.MAX_LOAD_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset),
      .instruction0(instruction0), .instruction1(instruction1),
      .pair_valid(pair_valid), .split_req(split_req),
      .load_valid(load_valid), .load_rt(load_rt), .mem_ready(mem_ready),
      .issue0(issue0), .issue1(issue1), .first(first),
      .stall_mask(stall_mask), .flush0(flush0), .flush1(flush1),
      .busy(busy), .load_timeout(load_timeout),
      .split_count(split_count), .wait_count(wait_count)
   );

   int checks   = 0;
   int failures = 0;

   // Model: "younger slot still owed" flag, "waiting on memory" flag with elapsed cycles.
   bit m_owed    = 0;
   bit m_waiting = 0;
   int m_waited  = 0;
   bit m_first   = 1;
   bit m_to      = 0;
   int m_splits  = 0;
   int m_holds   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int rs, input int rt);
      logic [31:0] v;
      v = $urandom;
      v[25:21] = rs[4:0];
      v[20:16] = rt[4:0];
      return v;
   endfunction

   function automatic int sat(input int v);
      return (v < 65535) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_owed = 0; m_waiting = 0; m_waited = 0; m_first = 1; m_to = 0; m_splits = 0; m_holds = 0;
   endtask

   // One clock: drive at negedge, compare shortly after, advance the model at posedge.
   task automatic step(input bit rst, input logic [31:0] i0, input logic [31:0] i1,
                       input bit pv, input bit sr, input bit lv, input logic [4:0] lrt, input bit mr);
      bit         hit, e_i0, e_i1, e_busy;
      logic [4:0] e_st, e_f0, e_f1;
      int         e_sc, e_wc;
      @(negedge clk);
      reset = rst; instruction0 = i0; instruction1 = i1; pair_valid = pv;
      split_req = sr; load_valid = lv; load_rt = lrt; mem_ready = mr;
      hit = lv && (lrt != 0) &&
            (i0[25:21] == lrt || i0[20:16] == lrt || i1[25:21] == lrt || i1[20:16] == lrt);
      e_i0 = 0; e_i1 = 0; e_st = 0; e_f0 = 0; e_f1 = 0;
      e_busy = !rst && (m_owed || m_waiting);
      if (rst) begin
      end else if (m_owed) begin
         if (m_first) begin e_i1 = 1; e_f0 = M_IFID; end
         else         begin e_i0 = 1; e_f1 = M_IFID; end
      end else if (m_waiting || (pv && hit)) begin
         e_st = M_PC | M_IFID; e_f0 = M_IDEX; e_f1 = M_IDEX;
      end else if (pv && sr) begin
         e_st = M_PC;
         if (m_first) begin e_i0 = 1; e_f1 = M_IDEX; end
         else         begin e_i1 = 1; e_f0 = M_IDEX; end
      end else if (pv) begin
         e_i0 = 1; e_i1 = 1;
      end
`ifdef SCHED_PERF_CNT_EN
      e_sc = m_splits; e_wc = m_holds;
`else
      e_sc = 0; e_wc = 0;
`endif
      #1;
      check("issue0", 32'(issue0), 32'(e_i0));
      check("issue1", 32'(issue1), 32'(e_i1));
      check("first", 32'(first), 32'(m_first));
      check("stall_mask", 32'(stall_mask), 32'(e_st));
      check("flush0", 32'(flush0), 32'(e_f0));
      check("flush1", 32'(flush1), 32'(e_f1));
      check("busy", 32'(busy), 32'(e_busy));
      check("load_timeout", 32'(load_timeout), 32'(m_to));
      check("split_count", 32'(split_count), 32'(e_sc));
      check("wait_count", 32'(wait_count), 32'(e_wc));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if ((e_st & M_IFID) != 0) m_holds = sat(m_holds);
         if (m_owed) begin
            m_owed  = 0;
            m_first = !m_first;
         end else if (m_waiting) begin
            m_waited++;
            if (mr) m_waiting = 0;
            else if (m_waited == MAXW) begin m_waiting = 0; m_to = 1; end
         end else if (pv && hit) begin
            if (!mr) begin m_waiting = 1; m_waited = 0; end
         end else if (pv && sr) begin
            m_owed   = 1;
            m_splits = sat(m_splits);
         end
      end
   endtask

   int exp_cnt;

   initial begin
      reset = 1; instruction0 = 0; instruction1 = 0; pair_valid = 0; split_req = 0;
      load_valid = 0; load_rt = 0; mem_ready = 0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state observed while reset is held
      step(1, mk(1, 2), mk(3, 1), 1, 0, 0, 0, 0);

      // Independent pair: dual issue, slot order unchanged
      step(0, mk(1, 2), mk(3, 4), 1, 0, 0, 0, 0);
      #1 check("plan_first_after_dual", 32'(first), 32'd1);

      // Dependent pair split over two cycles
      step(0, mk(1, 2), mk(2, 3), 1, 1, 0, 0, 0);
      step(0, mk(1, 2), mk(2, 3), 1, 1, 0, 0, 0);
      #1 check("plan_first_after_split", 32'(first), 32'd0);
`ifdef SCHED_PERF_CNT_EN
      exp_cnt = 1;
`else
      exp_cnt = 0;
`endif
      check("plan_split_count", 32'(split_count), 32'(exp_cnt));

      // Load-use with memory late for three cycles
      step(0, mk(1, 2), mk(5, 3), 1, 0, 1, 5'd5, 0);
      step(0, mk(1, 2), mk(5, 3), 1, 0, 1, 5'd5, 0);
      step(0, mk(1, 2), mk(5, 3), 1, 0, 1, 5'd5, 0);
      step(0, mk(1, 2), mk(5, 3), 1, 0, 1, 5'd5, 1);
      #1 check("plan_busy_after_wait", 32'(busy), 32'd0);
`ifdef SCHED_PERF_CNT_EN
      exp_cnt = 4;
`else
      exp_cnt = 0;
`endif
      check("plan_wait_count", 32'(wait_count), 32'(exp_cnt));

      // load_rt = 0 never hits
      step(0, mk(0, 0), mk(0, 7), 1, 0, 1, 5'd0, 0);

      // Load wait timeout after MAXW cycles, then sticky
      step(0, mk(9, 2), mk(3, 4), 1, 0, 1, 5'd9, 0);
      for (int i = 0; i < MAXW; i++) step(0, mk(9, 2), mk(3, 4), 1, 0, 1, 5'd9, 0);
      #1 check("plan_timeout_set", 32'(load_timeout), 32'd1);
      for (int i = 0; i < 4; i++) step(0, mk(1, 2), mk(3, 4), 1, 0, 0, 0, 1);
      #1 check("plan_timeout_sticky", 32'(load_timeout), 32'd1);

      // Reset in SPLIT drops the owed younger slot
      step(0, mk(1, 2), mk(2, 3), 1, 1, 0, 0, 0);
      step(1, mk(1, 2), mk(2, 3), 1, 1, 0, 0, 0);
      #1 check("plan_first_after_reset", 32'(first), 32'd1);
      check("plan_split_cnt_reset", 32'(split_count), 32'd0);
      check("plan_timeout_reset", 32'(load_timeout), 32'd0);
      step(0, mk(1, 2), mk(2, 3), 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 63) == 0),
              mk($urandom_range(0, 3), $urandom_range(0, 3)),
              mk($urandom_range(0, 3), $urandom_range(0, 3)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
